left_normalizer: RTL and testbench

Post-add normalization stage of the floating point adder/subtractor, paired with the right barrel shifter that aligns mantissas before the add. The block accepts the raw 25-bit sum mantissa and the pre-add exponent. It corrects carry-out with a one-place right shift, or removes leading zeros with a left shift, and adjusts the exponent to match. It is a 2-stage valid/ready pipeline that sits between the mantissa adder and the rounding/packing logic.

---
 rtl/left_normalizer_pkg.sv | 7 +
 rtl/left_normalizer_if.sv | 19 +
 rtl/left_normalizer_lzc.sv | 12 +
 rtl/left_normalizer.sv | 87 ++++++++
 tb/tb_left_normalizer.sv | 127 ++++++++++++
 5 files changed

// File: rtl/left_normalizer_pkg.sv
// left_normalizer_pkg: shared FP widths, exponent limit and sum-classification encoding
package left_normalizer_pkg;
  localparam int DATA_SIZE = 25;
  localparam int EXP_SIZE = 8;
  localparam logic [EXP_SIZE-1:0] EXP_MAX = 8'd255;
  typedef enum logic [1:0] {CLS_ZERO, CLS_CARRY, CLS_NORMAL, CLS_UNDER} cls_t;
endpackage

// File: rtl/left_normalizer_if.sv
// left_normalizer_if: valid/ready input and output channels of the normalizer
interface left_normalizer_if;
  import left_normalizer_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DATA_SIZE-1:0] in_mantissa;
  logic [EXP_SIZE-1:0] in_exponent;
  logic out_valid;
  logic out_ready;
  logic [DATA_SIZE-2:0] out_mantissa;
  logic [EXP_SIZE-1:0] out_exponent;
  logic out_zero;
  logic out_overflow;
  logic out_underflow;
  modport slave(input in_valid, in_mantissa, in_exponent, out_ready,
                output in_ready, out_valid, out_mantissa, out_exponent, out_zero, out_overflow, out_underflow);
  modport master(output in_valid, in_mantissa, in_exponent, out_ready,
                 input in_ready, out_valid, out_mantissa, out_exponent, out_zero, out_overflow, out_underflow);
endinterface

// File: rtl/left_normalizer_lzc.sv
// leading_zero_counter: leading zeros of a 24-bit word counted from bit 23, plus all-zero flag
module leading_zero_counter (
  input  logic [23:0] value,
  output logic [4:0]  count,
  output logic        zero
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 24; i++) if (value[i]) count = 5'(23 - i);
  end
  assign zero = ~|value;
endmodule

// File: rtl/left_normalizer.sv
// left_normalizer: two-stage post-add normalization (carry shift / leading-zero shift, exponent fix-up)
module left_normalizer
  import left_normalizer_pkg::*;
(
  input logic clk,
  input logic rst,
  left_normalizer_if.slave bus
);
  logic advance;
  logic [4:0] lz;
  logic lz_zero;
  cls_t cls;
  logic v1;
  logic [DATA_SIZE-1:0] m1;
  logic [EXP_SIZE-1:0] e1;
  cls_t c1;
  logic [4:0] lz1;
  logic [EXP_SIZE:0] e_inc;
  logic [DATA_SIZE-2:0] sh;
  logic [DATA_SIZE-2:0] nm;
  logic [EXP_SIZE-1:0] ne;
  logic nz, no, nu;
  assign advance = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  leading_zero_counter u_lzc (
    .value(bus.in_mantissa[DATA_SIZE-2:0]),
    .count(lz),
    .zero(lz_zero)
  );
  always_comb
    cls = (lz_zero && !bus.in_mantissa[DATA_SIZE-1]) ? CLS_ZERO :
          bus.in_mantissa[DATA_SIZE-1] ? CLS_CARRY :
          (bus.in_exponent > {3'b0, lz}) ? CLS_NORMAL : CLS_UNDER;
  // Shift lives here, fed by the registered count, so LZ and shift delays sit in separate stages
  always_comb begin
    sh = m1[DATA_SIZE-2:0];
    for (int s = 0; s < 5; s++) sh = lz1[s] ? sh << (1 << s) : sh;
  end
  always_comb begin
    e_inc = {1'b0, e1} + 9'd1;
    nm = '0;
    ne = '0;
    nz = 1'b0;
    no = 1'b0;
    nu = 1'b0;
    case (c1)
      CLS_ZERO: nz = 1'b1;
      CLS_CARRY: begin
        no = e_inc >= {1'b0, EXP_MAX};
        nm = no ? '0 : m1[DATA_SIZE-1:1];
        ne = no ? EXP_MAX : e_inc[EXP_SIZE-1:0];
      end
      CLS_NORMAL: begin
        nm = sh;
        ne = e1 - {3'b0, lz1};
      end
      default: nu = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      m1 <= '0;
      e1 <= '0;
      c1 <= CLS_ZERO;
      lz1 <= '0;
      bus.out_valid <= 1'b0;
      bus.out_mantissa <= '0;
      bus.out_exponent <= '0;
      bus.out_zero <= 1'b0;
      bus.out_overflow <= 1'b0;
      bus.out_underflow <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      m1 <= bus.in_mantissa;
      e1 <= bus.in_exponent;
      c1 <= cls;
      lz1 <= lz;
      bus.out_valid <= v1;
      bus.out_mantissa <= nm;
      bus.out_exponent <= ne;
      bus.out_zero <= nz;
      bus.out_overflow <= no;
      bus.out_underflow <= nu;
    end
  end
endmodule

// File: tb/tb_left_normalizer.sv
// tb_left_normalizer: directed vectors with hand-computed results, backpressure and mid-stream reset
module tb_left_normalizer;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  left_normalizer_if bus ();
  left_normalizer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [2:0] flags();
    return {bus.out_zero, bus.out_overflow, bus.out_underflow};
  endfunction
  task automatic run_vec(input string tag, input logic [24:0] m, input logic [7:0] e,
                         input logic [23:0] xm, input logic [7:0] xe, input logic [2:0] xf);
    check({tag, "_rdy"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_mantissa = m;
    bus.in_exponent = e;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 32'(bus.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_mant"}, 32'(bus.out_mantissa), 32'(xm));
    check({tag, "_exp"}, 32'(bus.out_exponent), 32'(xe));
    check({tag, "_flags"}, 32'(flags()), 32'(xf));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exponent = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_ready", 32'(bus.in_ready), 1);
    check("rst_mant", 32'(bus.out_mantissa), 0);
    check("rst_exp", 32'(bus.out_exponent), 0);
    check("rst_flags", 32'(flags()), 0);
    @(posedge clk);
    #1;
    run_vec("normal", 25'h0800000, 8'd127, 24'h800000, 8'd127, 3'b000);
    run_vec("carry", 25'h1800001, 8'd127, 24'hC00000, 8'd128, 3'b000);
    run_vec("ovf", 25'h1000000, 8'd254, 24'h000000, 8'd255, 3'b010);
    run_vec("lz15", 25'h0000100, 8'd100, 24'h800000, 8'd85, 3'b000);
    run_vec("lz23", 25'h0000001, 8'd24, 24'h800000, 8'd1, 3'b000);
    run_vec("unf15", 25'h0000100, 8'd15, 24'h000000, 8'd0, 3'b001);
    run_vec("unf23", 25'h0000001, 8'd23, 24'h000000, 8'd0, 3'b001);
    run_vec("zero", 25'h0000000, 8'd90, 24'h000000, 8'd0, 3'b100);
    run_vec("carry_all", 25'h1FFFFFF, 8'd10, 24'hFFFFFF, 8'd11, 3'b000);
    run_vec("lz3", 25'h0123456, 8'd50, 24'h91A2B0, 8'd47, 3'b000);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mantissa = 25'h0800000;
    bus.in_exponent = 8'd127;
    @(posedge clk);
    #1 bus.in_mantissa = 25'h1800001;
    @(posedge clk);
    #1 bus.in_mantissa = 25'h0000100;
    bus.in_exponent = 8'd100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(bus.in_ready), 0);
      check("bp_hold", {bus.out_valid, 7'd0, bus.out_mantissa}, {1'b1, 7'd0, 24'h800000});
      check("bp_hold_exp", 32'(bus.out_exponent), 127);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_o0", {bus.out_valid, bus.out_mantissa, bus.out_exponent[6:0]}, {1'b1, 24'h800000, 7'd127});
    @(posedge clk);
    #1 bus.in_mantissa = 25'h0400000;
    bus.in_exponent = 8'd10;
    @(negedge clk);
    check("bp_o1", {bus.out_valid, 7'd0, bus.out_mantissa}, {1'b1, 7'd0, 24'hC00000});
    check("bp_o1_exp", 32'(bus.out_exponent), 128);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_o2", {bus.out_valid, 7'd0, bus.out_mantissa}, {1'b1, 7'd0, 24'h800000});
    check("bp_o2_exp", 32'(bus.out_exponent), 85);
    @(posedge clk);
    @(negedge clk);
    check("bp_o3", {bus.out_valid, 7'd0, bus.out_mantissa}, {1'b1, 7'd0, 24'h800000});
    check("bp_o3_exp", 32'(bus.out_exponent), 9);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mantissa = 25'h1800001;
    bus.in_exponent = 8'd127;
    @(posedge clk);
    #1 bus.in_mantissa = 25'h0000100;
    bus.in_exponent = 8'd100;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(bus.out_valid), 0);
    check("mrst_ready", 32'(bus.in_ready), 1);
    check("mrst_out", {bus.out_mantissa, bus.out_exponent}, 32'd0);
    check("mrst_flags", 32'(flags()), 0);
    run_vec("post_rst", 25'h1800001, 8'd127, 24'hC00000, 8'd128, 3'b000);
    @(negedge clk);
    check("drain", 32'(bus.out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
